wb_slave_arbiter: RTL

//  Round-robin Wishbone B3 arbiter sharing one slave port (the testing_wb_slave register bank) among NM masters.

---
 rtl/wb_slave_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/wb_slave_arbiter.sv
// Round-robin Wishbone B3 arbiter: NM masters share one slave port, grant held for a
// whole cyc, with a per-strobe watchdog that terminates hung accesses with err.
module wb_slave_arbiter #(
  parameter int unsigned NM      = 4,
  parameter int unsigned dw      = 32,
  parameter int unsigned aw      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic [NM*aw-1:0]  m_adr_i,
  input  logic [NM*dw-1:0]  m_dat_i,
  input  logic [NM*4-1:0]   m_sel_i,
  input  logic [NM-1:0]     m_we_i,
  input  logic [NM-1:0]     m_cyc_i,
  input  logic [NM-1:0]     m_stb_i,
  input  logic [NM*3-1:0]   m_cti_i,
  input  logic [NM*2-1:0]   m_bte_i,
  output logic [dw-1:0]     m_dat_o,
  output logic [NM-1:0]     m_ack_o,
  output logic [NM-1:0]     m_err_o,
  output logic [NM-1:0]     m_rty_o,
  output logic [aw-1:0]     s_adr_o,
  output logic [dw-1:0]     s_dat_o,
  output logic [3:0]        s_sel_o,
  output logic              s_we_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic [2:0]        s_cti_o,
  output logic [1:0]        s_bte_o,
  input  logic [dw-1:0]     s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_rty_i,
  output logic [NM-1:0]     grant_o,
  output logic              busy_o
);

  localparam int unsigned LW    = (NM > 1) ? $clog2(NM) : 1;
  localparam int unsigned WW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          WD_EN = (TIMEOUT > 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [NM-1:0]   grant_q, grant_d;
  logic [LW-1:0]   last_q, last_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic [LW-1:0]   cand;
  logic            found;
  logic            active;
  logic            resp;
  logic            stb_raw;
  logic            fire;

  assign grant_o = grant_q;
  assign busy_o  = (state_q == BUSY);

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LW'(NM - 1);
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  // While BUSY, last_q is the index of the owning master.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wdog_d  = '0;
    cand    = '0;
    found   = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    m_dat_o = s_dat_i;

    active  = (state_q == BUSY) && !wb_rst;
    resp    = s_ack_i || s_err_i || s_rty_i;
    stb_raw = active && m_cyc_i[last_q] && m_stb_i[last_q];
    // A real slave response on the expiry cycle takes priority over the timeout.
    fire    = WD_EN && stb_raw && !resp && (wdog_q == WW'(TIMEOUT));

    case (state_q)
      IDLE: begin
        for (int i = 1; i <= int'(NM); i++) begin
          if (!found) begin
            cand = LW'((int'(last_q) + i) % int'(NM));
            if (m_cyc_i[cand]) begin
              found         = 1'b1;
              last_d        = cand;
              grant_d       = '0;
              grant_d[cand] = 1'b1;
              state_d       = BUSY;
            end
          end
        end
      end
      BUSY: begin
        if (!m_cyc_i[last_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (active) begin
      s_adr_o         = m_adr_i[last_q*aw +: aw];
      s_dat_o         = m_dat_i[last_q*dw +: dw];
      s_sel_o         = m_sel_i[last_q*4 +: 4];
      s_cti_o         = m_cti_i[last_q*3 +: 3];
      s_bte_o         = m_bte_i[last_q*2 +: 2];
      s_we_o          = m_we_i[last_q];
      s_cyc_o         = m_cyc_i[last_q];
      s_stb_o         = stb_raw && !fire;
      m_ack_o[last_q] = s_ack_i && m_stb_i[last_q];
      m_err_o[last_q] = (s_err_i && m_stb_i[last_q]) || fire;
      m_rty_o[last_q] = s_rty_i && m_stb_i[last_q];
      if (WD_EN && stb_raw && !resp && !fire)
        wdog_d = wdog_q + 1'b1;
    end
  end

endmodule
